// File: rtl/remap_decoder_if.sv
// Requester-side handshake bundle for remap_decoder:
// address decode, transaction retire and remap configuration.
interface remap_decoder_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int N_INIT_PORT = 8,
  parameter int N_REGION    = 3,
  parameter int LOG_N_INIT  = 3
);
  logic                                 addr_valid_i;
  logic [ADDR_WIDTH-1:0]                addr_i;
  logic                                 addr_ready_o;
  logic                                 match_valid_o;
  logic [N_REGION-1:0][N_INIT_PORT-1:0] match_region_o;
  logic                                 txn_done_i;
  logic                                 cfg_req_i;
  logic [1:0]                           cfg_op_i;
  logic [LOG_N_INIT-1:0]                cfg_src_i;
  logic [LOG_N_INIT-1:0]                cfg_dst_i;
  logic                                 cfg_ack_o;
  logic                                 cfg_err_o;

  modport master (
    output addr_valid_i, addr_i, txn_done_i,
    output cfg_req_i, cfg_op_i, cfg_src_i, cfg_dst_i,
    input  addr_ready_o, match_valid_o, match_region_o,
    input  cfg_ack_o, cfg_err_o
  );

  modport slave (
    input  addr_valid_i, addr_i, txn_done_i,
    input  cfg_req_i, cfg_op_i, cfg_src_i, cfg_dst_i,
    output addr_ready_o, match_valid_o, match_region_o,
    output cfg_ack_o, cfg_err_o
  );
endinterface

// File: rtl/remap_decoder.sv
// Region address decoder with a runtime port remap table.
// Remaps are applied only after outstanding traffic drains.
module remap_decoder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int N_INIT_PORT   = 8,
  parameter int N_REGION      = 3,
  parameter int LOG_N_INIT    = 3,
  parameter int MAX_OUT       = 15,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0] enable_region_i,
  remap_decoder_if.slave bus,
  output logic busy_o
);

  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int DTW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int NIX = 1 << LOG_N_INIT;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    APPLY,
    ACK
  } state_e;

  state_e state_q, state_d;

  logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0] map_q, map_d;
  logic [CW-1:0]  count_q, count_d;
  logic [DTW-1:0] drain_q, drain_d;
  logic [1:0]     op_q, op_d;
  logic [LOG_N_INIT-1:0] src_q, src_d;
  logic [LOG_N_INIT-1:0] dst_q, dst_d;
  logic err_q, err_d;
  logic match_valid_q, match_valid_d;
  logic [N_REGION-1:0][N_INIT_PORT-1:0] match_region_q, match_region_d;

  logic accept;
  logic retire;
  logic [NIX-1:0] idx_ok;

  assign bus.addr_ready_o   = (state_q == IDLE) && (count_q < CW'(MAX_OUT));
  assign accept             = bus.addr_valid_i && bus.addr_ready_o;
  assign retire             = bus.txn_done_i && (count_q != '0);
  assign bus.match_valid_o  = match_valid_q;
  assign bus.match_region_o = match_region_q;
  assign bus.cfg_ack_o      = (state_q == ACK);
  assign bus.cfg_err_o      = (state_q == ACK) && err_q;
  assign busy_o             = (state_q == DRAIN) || (state_q == APPLY);

  // Table of which encodable port indices actually exist.
  always_comb begin
    idx_ok = '0;
    for (int k = 0; k < NIX; k++) begin
      idx_ok[k] = (k < N_INIT_PORT);
    end
  end

  // Decode the address through the current remap; overlapping targets OR together.
  always_comb begin
    match_valid_d  = accept;
    match_region_d = '0;
    if (accept) begin
      for (int j = 0; j < N_REGION; j++) begin
        for (int i = 0; i < N_INIT_PORT; i++) begin
          if (enable_region_i[j][i] &&
              bus.addr_i >= START_ADDR_i[j][i] &&
              bus.addr_i <= END_ADDR_i[j][i]) begin
            match_region_d[j][map_q[i]] = 1'b1;
          end
        end
      end
    end
  end

  // Outstanding transaction counter; simultaneous accept and retire cancel.
  always_comb begin
    count_d = count_q;
    if (accept && !retire) begin
      count_d = count_q + CW'(1);
    end else if (!accept && retire) begin
      count_d = count_q - CW'(1);
    end
  end

  // Reconfiguration FSM: latch request, drain, apply remap, acknowledge.
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    drain_d = drain_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        drain_d = '0;
        if (bus.cfg_req_i) begin
          op_d  = bus.cfg_op_i;
          src_d = bus.cfg_src_i;
          dst_d = bus.cfg_dst_i;
          if (bus.cfg_op_i == 2'b11 ||
              !idx_ok[bus.cfg_src_i] ||
              !idx_ok[bus.cfg_dst_i]) begin
            err_d   = 1'b1;
            state_d = ACK;
          end else begin
            err_d   = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (count_q == '0 && !match_valid_q) begin
          state_d = APPLY;
        end else if (drain_q == DTW'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          drain_d = drain_q + DTW'(1);
        end
      end
      APPLY: begin
        unique case (op_q)
          2'b00: map_d[src_q] = dst_q;
          2'b01: begin
            map_d[src_q] = map_q[dst_q];
            map_d[dst_q] = map_q[src_q];
          end
          2'b10: begin
            for (int i = 0; i < N_INIT_PORT; i++) begin
              map_d[i] = LOG_N_INIT'(i);
            end
          end
          default: ;
        endcase
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any pending request silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      for (int i = 0; i < N_INIT_PORT; i++) begin
        map_q[i] <= LOG_N_INIT'(i);
      end
      count_q        <= '0;
      drain_q        <= '0;
      op_q           <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      err_q          <= 1'b0;
      match_valid_q  <= 1'b0;
      match_region_q <= '0;
    end else begin
      state_q        <= state_d;
      map_q          <= map_d;
      count_q        <= count_d;
      drain_q        <= drain_d;
      op_q           <= op_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      err_q          <= err_d;
      match_valid_q  <= match_valid_d;
      match_region_q <= match_region_d;
    end
  end

endmodule

// File: tb/tb_remap_decoder.sv
// Directed self-checking bench for remap_decoder.
// Port i of region 0 owns 0x10000*(i+1) .. +0xFFFF.
module tb_remap_decoder;

  localparam int AW = 32;
  localparam int NP = 8;
  localparam int NR = 3;
  localparam int LN = 3;
  localparam int MO = 15;
  localparam int DT = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0][NP-1:0][AW-1:0] start_a;
  logic [NR-1:0][NP-1:0][AW-1:0] end_a;
  logic [NR-1:0][NP-1:0] en;
  logic busy;

  int total = 0;
  int bad = 0;

  remap_decoder_if #(
    .ADDR_WIDTH(AW), .N_INIT_PORT(NP),
    .N_REGION(NR), .LOG_N_INIT(LN)
  ) bus ();

  remap_decoder #(
    .ADDR_WIDTH(AW), .N_INIT_PORT(NP), .N_REGION(NR),
    .LOG_N_INIT(LN), .MAX_OUT(MO), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .START_ADDR_i(start_a),
    .END_ADDR_i(end_a),
    .enable_region_i(en),
    .bus(bus),
    .busy_o(busy)
  );

  task automatic do_decode(input logic [31:0] a, output logic v,
                           output logic [2:0][7:0] m, output logic v_after);
    @(negedge clk);
    bus.addr_valid_i = 1'b1;
    bus.addr_i = a;
    @(negedge clk);
    bus.addr_valid_i = 1'b0;
    v = bus.match_valid_o;
    m = bus.match_region_o;
    bus.txn_done_i = 1'b1;
    @(negedge clk);
    bus.txn_done_i = 1'b0;
    v_after = bus.match_valid_o;
  endtask

  task automatic do_cfg(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                        input int limit, output logic got, output logic err,
                        output logic ack_after, output int cyc);
    int c;
    got = 1'b0;
    err = 1'b0;
    @(negedge clk);
    bus.cfg_req_i = 1'b1;
    bus.cfg_op_i = op;
    bus.cfg_src_i = s;
    bus.cfg_dst_i = d;
    for (c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.cfg_op_i = 2'b10;
        bus.cfg_src_i = ~s;
        bus.cfg_dst_i = ~d;
      end
      if (bus.cfg_ack_o) begin
        got = 1'b1;
        err = bus.cfg_err_o;
        break;
      end
    end
    cyc = c;
    bus.cfg_req_i = 1'b0;
    @(negedge clk);
    ack_after = bus.cfg_ack_o;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.addr_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.addr_ready_o); end
    total++; if (bus.match_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mvalid: got %b want 0", bus.match_valid_o); end
    total++; if (bus.match_region_o !== 24'h0) begin bad++; $display("FAIL rst_region: got %h want 0", bus.match_region_o); end
    total++; if (bus.cfg_ack_o !== 1'b0 || bus.cfg_err_o !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b%b want 00", bus.cfg_ack_o, bus.cfg_err_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    logic v, va;
    logic [2:0][7:0] m;
    do_decode(32'h1800, v, m, va);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL id_valid: got %b want 1", v); end
    total++; if (m !== {8'h00, 8'h04, 8'h00}) begin bad++; $display("FAIL id_1800: got %h want 000400", m); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL id_valid_drop: got %b want 0", va); end
    do_decode(32'h2800, v, m, va);
    total++; if (m !== {8'h24, 8'h00, 8'h00}) begin bad++; $display("FAIL id_or_2800: got %h want 240000", m); end
    do_decode(32'h70010, v, m, va);
    total++; if (m !== {8'h00, 8'h00, 8'h40}) begin bad++; $display("FAIL id_port6: got %h want 000040", m); end
  endtask

  task automatic test_move_under_load();
    logic v, va;
    logic [2:0][7:0] m;
    logic got, err;
    int c;
    @(negedge clk);
    bus.addr_valid_i = 1'b1;
    bus.addr_i = 32'h1800;
    repeat (3) @(negedge clk);
    bus.addr_valid_i = 1'b0;
    bus.cfg_req_i = 1'b1;
    bus.cfg_op_i = 2'b00;
    bus.cfg_src_i = 3'd2;
    bus.cfg_dst_i = 3'd5;
    @(negedge clk);
    bus.cfg_op_i = 2'b10;
    bus.cfg_src_i = 3'd7;
    bus.cfg_dst_i = 3'd0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mv_busy: got %b want 1", busy); end
    total++; if (bus.addr_ready_o !== 1'b0) begin bad++; $display("FAIL mv_ready: got %b want 0", bus.addr_ready_o); end
    for (int k = 0; k < 3; k++) begin
      bus.txn_done_i = 1'b1;
      @(negedge clk);
      bus.txn_done_i = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        total++; if (busy !== 1'b1 || bus.addr_ready_o !== 1'b0) begin bad++; $display("FAIL mv_hold: got busy=%b ready=%b want 1 0", busy, bus.addr_ready_o); end
      end
    end
    got = 1'b0;
    err = 1'b0;
    for (c = 0; c < 10; c++) begin
      if (bus.cfg_ack_o) begin
        got = 1'b1;
        err = bus.cfg_err_o;
        break;
      end
      @(negedge clk);
    end
    bus.cfg_req_i = 1'b0;
    total++; if (got !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL mv_ack: got ack=%b err=%b want 1 0", got, err); end
    @(negedge clk);
    total++; if (bus.cfg_ack_o !== 1'b0) begin bad++; $display("FAIL mv_ack_pulse: got %b want 0", bus.cfg_ack_o); end
    do_decode(32'h1800, v, m, va);
    total++; if (m !== {8'h00, 8'h20, 8'h00}) begin bad++; $display("FAIL mv_1800: got %h want 002000", m); end
    do_decode(32'h2800, v, m, va);
    total++; if (m !== {8'h20, 8'h00, 8'h00}) begin bad++; $display("FAIL mv_or_2800: got %h want 200000", m); end
  endtask

  task automatic test_swap_restore();
    logic v, va;
    logic [2:0][7:0] m;
    logic got, err, aa;
    int c;
    do_cfg(2'b01, 3'd0, 3'd7, 10, got, err, aa, c);
    total++; if (got !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL sw_ack: got ack=%b err=%b want 1 0", got, err); end
    do_decode(32'h10010, v, m, va);
    total++; if (m !== {8'h00, 8'h00, 8'h80}) begin bad++; $display("FAIL sw_port0: got %h want 000080", m); end
    do_decode(32'h80010, v, m, va);
    total++; if (m !== {8'h00, 8'h00, 8'h01}) begin bad++; $display("FAIL sw_port7: got %h want 000001", m); end
    do_cfg(2'b10, 3'd3, 3'd4, 10, got, err, aa, c);
    total++; if (got !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL rs_ack: got ack=%b err=%b want 1 0", got, err); end
    do_decode(32'h10010, v, m, va);
    total++; if (m !== {8'h00, 8'h00, 8'h01}) begin bad++; $display("FAIL rs_port0: got %h want 000001", m); end
    do_decode(32'h1800, v, m, va);
    total++; if (m !== {8'h00, 8'h04, 8'h00}) begin bad++; $display("FAIL rs_1800: got %h want 000400", m); end
  endtask

  task automatic test_errors();
    logic v, va;
    logic [2:0][7:0] m;
    logic got, err, aa;
    int c;
    do_cfg(2'b11, 3'd1, 3'd2, 10, got, err, aa, c);
    total++; if (got !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL op11_ack: got ack=%b err=%b want 1 1", got, err); end
    total++; if (c !== 1) begin bad++; $display("FAIL op11_latency: got %0d want 1", c); end
    total++; if (aa !== 1'b0) begin bad++; $display("FAIL op11_pulse: got %b want 0", aa); end
    @(negedge clk);
    bus.addr_valid_i = 1'b1;
    bus.addr_i = 32'h1800;
    @(negedge clk);
    bus.addr_valid_i = 1'b0;
    do_cfg(2'b00, 3'd1, 3'd4, 400, got, err, aa, c);
    total++; if (got !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL to_ack: got ack=%b err=%b want 1 1", got, err); end
    total++; if (c < DT || c > DT + 3) begin bad++; $display("FAIL to_latency: got %0d want %0d..%0d", c, DT, DT + 3); end
    @(negedge clk);
    bus.txn_done_i = 1'b1;
    @(negedge clk);
    bus.txn_done_i = 1'b0;
    do_decode(32'h20010, v, m, va);
    total++; if (m !== {8'h00, 8'h00, 8'h02}) begin bad++; $display("FAIL to_map: got %h want 000002", m); end
  endtask

  task automatic test_count();
    logic v, va;
    logic [2:0][7:0] m;
    logic got, err, aa;
    int c;
    @(negedge clk);
    bus.txn_done_i = 1'b1;
    @(negedge clk);
    bus.txn_done_i = 1'b0;
    bus.addr_valid_i = 1'b1;
    bus.addr_i = 32'h1800;
    repeat (14) @(negedge clk);
    total++; if (bus.addr_ready_o !== 1'b1) begin bad++; $display("FAIL cnt14_ready: got %b want 1", bus.addr_ready_o); end
    bus.txn_done_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.txn_done_i = 1'b0;
    total++; if (bus.addr_ready_o !== 1'b1) begin bad++; $display("FAIL cnt_simul: got %b want 1", bus.addr_ready_o); end
    @(negedge clk);
    total++; if (bus.addr_ready_o !== 1'b0) begin bad++; $display("FAIL cnt_max_ready: got %b want 0", bus.addr_ready_o); end
    repeat (2) @(negedge clk);
    total++; if (bus.match_valid_o !== 1'b0) begin bad++; $display("FAIL cnt_max_noacc: got %b want 0", bus.match_valid_o); end
    bus.addr_valid_i = 1'b0;
    bus.txn_done_i = 1'b1;
    repeat (15) @(negedge clk);
    bus.txn_done_i = 1'b0;
    total++; if (bus.addr_ready_o !== 1'b1) begin bad++; $display("FAIL cnt_drained: got %b want 1", bus.addr_ready_o); end
    do_cfg(2'b00, 3'd3, 3'd3, 10, got, err, aa, c);
    total++; if (got !== 1'b1 || err !== 1'b0 || c !== 3) begin bad++; $display("FAIL cnt_zero_cfg: got ack=%b err=%b cyc=%0d want 1 0 3", got, err, c); end
    do_decode(32'h40010, v, m, va);
    total++; if (m !== {8'h00, 8'h00, 8'h08}) begin bad++; $display("FAIL same_move: got %h want 000008", m); end
  endtask

  task automatic test_reset_in_drain();
    logic v, va;
    logic [2:0][7:0] m;
    logic got, err, aa, seen;
    int c;
    do_cfg(2'b00, 3'd0, 3'd3, 10, got, err, aa, c);
    do_decode(32'h10010, v, m, va);
    total++; if (m !== {8'h00, 8'h00, 8'h08}) begin bad++; $display("FAIL rd_pre_move: got %h want 000008", m); end
    @(negedge clk);
    bus.addr_valid_i = 1'b1;
    bus.addr_i = 32'h1800;
    @(negedge clk);
    bus.addr_valid_i = 1'b0;
    bus.cfg_req_i = 1'b1;
    bus.cfg_op_i = 2'b00;
    bus.cfg_src_i = 3'd1;
    bus.cfg_dst_i = 3'd6;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || bus.cfg_ack_o !== 1'b0) begin bad++; $display("FAIL rd_async: got busy=%b ack=%b want 0 0", busy, bus.cfg_ack_o); end
    bus.cfg_req_i = 1'b0;
    bus.txn_done_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | bus.cfg_ack_o;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rd_noack: got %b want 0", seen); end
    total++; if (bus.addr_ready_o !== 1'b1) begin bad++; $display("FAIL rd_ready: got %b want 1", bus.addr_ready_o); end
    do_decode(32'h10010, v, m, va);
    total++; if (m !== {8'h00, 8'h00, 8'h01}) begin bad++; $display("FAIL rd_identity: got %h want 000001", m); end
  endtask

  initial begin
    bus.addr_valid_i = 1'b0;
    bus.addr_i = '0;
    bus.txn_done_i = 1'b0;
    bus.cfg_req_i = 1'b0;
    bus.cfg_op_i = '0;
    bus.cfg_src_i = '0;
    bus.cfg_dst_i = '0;
    start_a = '0;
    end_a = '0;
    en = '0;
    for (int i = 0; i < NP; i++) begin
      start_a[0][i] = 32'h10000 * (i + 1);
      end_a[0][i] = 32'h10000 * (i + 1) + 32'hFFFF;
      en[0][i] = 1'b1;
    end
    start_a[1][2] = 32'h1000; end_a[1][2] = 32'h1FFF; en[1][2] = 1'b1;
    start_a[1][3] = 32'h1000; end_a[1][3] = 32'h1FFF; en[1][3] = 1'b0;
    start_a[2][2] = 32'h2000; end_a[2][2] = 32'h2FFF; en[2][2] = 1'b1;
    start_a[2][5] = 32'h2000; end_a[2][5] = 32'h2FFF; en[2][5] = 1'b1;
    test_reset();
    test_identity();
    test_move_under_load();
    test_swap_restore();
    test_errors();
    test_count();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/remap_decoder.md
REMAP_DECODER -- requirements
Module: remap_decoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-002 SHALL have parameter N_INIT_PORT, default 8, meaning number of initiator ports.
REQ-003 SHALL have parameter N_REGION, default 3, meaning number of address regions per port.
REQ-004 SHALL have parameter LOG_N_INIT, default 3, meaning port index width, equal to clog2(N_INIT_PORT).
REQ-005 SHALL have parameter MAX_OUT, default 15, meaning maximum outstanding decoded transactions.
REQ-006 SHALL have parameter DRAIN_TIMEOUT, default 256, meaning drain watchdog limit in cycles.
REQ-007 SHALL have clk  input  1  clock.
REQ-008 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have START_ADDR_i, END_ADDR_i  input  N_REGION x N_INIT_PORT x ADDR_WIDTH  inclusive region bounds.
REQ-010 SHALL have enable_region_i  input  N_REGION x N_INIT_PORT  region enables.
REQ-011 SHALL have addr_valid_i  input  1  address request.
REQ-012 SHALL have addr_i  input  ADDR_WIDTH  address.
REQ-013 SHALL have addr_ready_o  output  1  address accepted.
REQ-014 SHALL have match_valid_o  output  1  decode result valid.
REQ-015 SHALL have match_region_o  output  N_REGION x N_INIT_PORT  remapped match vector.
REQ-016 SHALL have txn_done_i  input  1  one outstanding transaction retired.
REQ-017 SHALL have cfg_req_i  input  1  reconfiguration request, level, held until ack.
REQ-018 SHALL have cfg_op_i  input  2  00 move, 01 swap, 10 restore, 11 reserved.
REQ-019 SHALL have cfg_src_i and cfg_dst_i  input  LOG_N_INIT  port indices.
REQ-020 SHALL have cfg_ack_o  output  1  one-cycle completion pulse.
REQ-021 SHALL have cfg_err_o  output  1  error status, valid only with cfg_ack_o.
REQ-022 SHALL have busy_o  output  1  high in DRAIN or APPLY.

Function
REQ-023 SHALL hold map_q[i] (LOG_N_INIT bits per port); reset value map_q[i]=i.
REQ-024 SHALL accept an address on a cycle where addr_valid_i && addr_ready_o.
REQ-025 SHALL register the result: match_valid_o is high exactly 1 cycle after acceptance and low otherwise.
REQ-026 SHALL set match_region_o[j][map_q[i]] for every i with START<=addr_i<=END and enable set, using map_q as sampled in the acceptance cycle; all other bits 0.
REQ-027 SHALL OR the matches when several ports map to the same target.
REQ-028 SHALL keep a 0..MAX_OUT outstanding counter: +1 on acceptance, -1 on txn_done_i; unchanged when both occur; txn_done_i at 0 ignored.
REQ-029 SHALL drive addr_ready_o = (state==IDLE) && (count<MAX_OUT).
REQ-030 SHALL implement FSM IDLE, DRAIN, APPLY, ACK.
REQ-031 SHALL, in IDLE with cfg_req_i=1, latch op, src and dst. On op 11 or an index >= N_INIT_PORT, it goes to ACK with error. Otherwise it goes to DRAIN.
REQ-032 SHALL, in DRAIN, go to APPLY when count==0 and match_valid_o==0. It goes to ACK with error when the drain counter reaches DRAIN_TIMEOUT cycles, leaving map_q unchanged.
REQ-033 SHALL, in APPLY (exactly one cycle), update map_q as follows and then go to ACK.
  - move: map_q[src]<=dst.
  - swap: map_q[src] and map_q[dst] exchange.
  - restore: map_q[i]<=i for all i.
REQ-034 SHALL treat swap or move with src==dst as legal: no change for swap, map_q[src]<=src for move, no error.
REQ-035 SHALL, in ACK, pulse cfg_ack_o for one cycle, with cfg_err_o=error flag, and return to IDLE.
REQ-036 SHALL require the requester to drop cfg_req_i on the edge sampling cfg_ack_o=1; IDLE samples cfg_req_i only as a new request.
REQ-037 SHALL ignore changes on cfg_op_i, cfg_src_i and cfg_dst_i after latching.

Reset
REQ-038 SHALL, on rst_n low, asynchronously set the following, including mid-DRAIN or mid-APPLY, with no ack issued for the aborted request:
  - state=IDLE
  - map_q to identity
  - count=0
  - drain counter=0
  - match_valid_o=0, match_region_o=0
  - cfg_ack_o=0, cfg_err_o=0, busy_o=0

Verification
REQ-039 SHALL cover identity decode: region[1][2]=0x1000..0x1FFF enabled, addr 0x1800 -> next cycle match_valid_o=1, match_region_o[1]=0b00000100.
REQ-040 SHALL cover move under load: 3 outstanding, move src=2 dst=5. Expected response:
  - busy_o=1, addr_ready_o=0 until 3 txn_done_i pulses.
  - APPLY, then ack with err=0.
  - addr 0x1800 gives match_region_o[1]=0b00100000.
REQ-041 SHALL cover swap 0<->7 then restore. Expected response:
  - After swap: map_q[0]=7, map_q[7]=0.
  - After restore: identity.
  - Each step acks with err=0.
REQ-042 SHALL cover errors. Expected response:
  - cfg_op_i=11: ack 1 cycle after request, err=1, map unchanged.
  - Drain stalled >DRAIN_TIMEOUT with count=1: ack with err=1, map unchanged.
REQ-043 SHALL cover simultaneous acceptance and txn_done_i: count is unchanged. Also cover count=MAX_OUT: addr_ready_o=0.
REQ-044 SHALL cover rst_n asserted in DRAIN: ack is never pulsed, map is identity, and addr_ready_o=1 after release.
